// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared types for the counter command sequencer: the command opcode
//   encoding seen on cmd_op, and the sequencer FSM state encoding.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_INC  = 2'b10,
        ST_RSP  = 2'b11
    } state_e;

endpackage : counter_ctrl_pkg

// File: rtl/repeat_down_counter.sv
// repeat_down_counter
//   WIDTH-bit loadable down-counter holding the remaining INC repeat count.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset (clears the count)
//     load_i         load load_value_i (has priority over dec_i)
//     load_value_i   repeat count to load
//     dec_i          decrement by one this cycle
//     last_o         count currently equals 1 (this is the final repeat)
module repeat_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        // NOTE: defaults first so every path assigns count_d; a missing
        // assignment on some path would infer a latch.
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            // Guard against underflow so a stray decrement at zero is harmless.
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == WIDTH'(1));

endmodule : repeat_down_counter

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Command sequencer for the 8-bit programmable counter. Accepts
//   LOAD / INC / READ commands on a valid/ready port, drives the counter's
//   load_enable / increment strobes cycle by cycle, and returns sampled
//   counter values on a valid/ready response port.
//   Ports:
//     clk, rst_n                   clock, synchronous active-low reset
//     cmd_valid/cmd_ready          command handshake
//     cmd_op, cmd_arg              opcode and LOAD value / INC repeat count
//     rsp_valid/rsp_ready          response handshake
//     rsp_data                     counter value sampled at READ accept
//     ctr_load, ctr_load_enable,   counter load interface
//     ctr_increment                counter increment strobe
//     ctr_value                    counter output
//     busy                         sequencer not idle
//     wrap                         one-cycle pulse after an increment from all-ones
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] ctr_load,
    output logic             ctr_load_enable,
    output logic             ctr_increment,
    input  logic [WIDTH-1:0] ctr_value,
    output logic             busy,
    output logic             wrap
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ctr_load_q, ctr_load_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             wrap_q, wrap_d;

    op_e  op;
    logic accept;
    logic rep_load;
    logic rep_last;

    assign op = op_e'(cmd_op);

    // Handshake and strobes are gated by rst_n so nothing is issued or
    // accepted during the reset cycle itself, before state has cleared.
    assign cmd_ready       = (state_q == ST_IDLE) && rst_n;
    assign accept          = cmd_valid && cmd_ready;
    assign ctr_load_enable = (state_q == ST_LOAD) && rst_n;
    assign ctr_increment   = (state_q == ST_INC)  && rst_n;

    assign rsp_valid = (state_q == ST_RSP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = rsp_data_q;
    assign ctr_load  = ctr_load_q;
    assign wrap      = wrap_q;

    repeat_down_counter #(
        .WIDTH (WIDTH)
    ) u_repeat (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (rep_load),
        .load_value_i (cmd_arg),
        .dec_i        (ctr_increment),
        .last_o       (rep_last)
    );

    always_comb begin
        state_d    = state_q;
        ctr_load_d = ctr_load_q;
        rsp_data_d = rsp_data_q;
        rep_load   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_LOAD: begin
                            ctr_load_d = cmd_arg;
                            state_d    = ST_LOAD;
                        end
                        OP_INC: begin
                            // INC 0 completes in the accept cycle with no strobe.
                            if (cmd_arg != '0) begin
                                rep_load = 1'b1;
                                state_d  = ST_INC;
                            end
                        end
                        OP_READ: begin
                            rsp_data_d = ctr_value;
                            state_d    = ST_RSP;
                        end
                        default: ; // OP_NOP: accepted, no side effect
                    endcase
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_INC: begin
                if (rep_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter rolls over on the edge that ends an increment cycle showing all-ones.
    assign wrap_d = ctr_increment && (ctr_value == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctr_load_q <= '0;
            rsp_data_q <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_load_q <= ctr_load_d;
            rsp_data_q <= rsp_data_d;
            wrap_q     <= wrap_d;
        end
    end

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

    localparam int WIDTH = 8;
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] ctr_load;
    logic             ctr_load_enable;
    logic             ctr_increment;
    logic [WIDTH-1:0] ctr_value;
    logic             busy;
    logic             wrap;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb[$];

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_arg         (cmd_arg),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .ctr_load        (ctr_load),
        .ctr_load_enable (ctr_load_enable),
        .ctr_increment   (ctr_increment),
        .ctr_value       (ctr_value),
        .busy            (busy),
        .wrap            (wrap)
    );

    // Behavioural model of the programmable counter the sequencer drives.
    logic [WIDTH-1:0] ctr_q;
    always @(posedge clk) begin
        if (!rst_n)               ctr_q <= '0;
        else if (ctr_load_enable) ctr_q <= ctr_load;
        else if (ctr_increment)   ctr_q <= ctr_q + 8'd1;
    end
    assign ctr_value = ctr_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every completed handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got 0x%0h with no expected response", rsp_data);
            end else begin
                check("rsp_data", {24'd0, rsp_data}, {24'd0, sb.pop_front()});
            end
        end
    end

    // Tasks enter and return just after a rising edge.
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] arg);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: cmd_ready never rose for op %0d", op);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy stuck high");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [WIDTH-1:0] exp);
        sb.push_back(exp);
        send(OP_READ, '0);
        wait_idle();
    endtask

    initial begin
        logic [7:0] inc_mask, rdy_mask, both_mask, wrap_mask;
        int n;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] inc_mask, rdy_mask, both_mask, wrap_mask;
        int n;

        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_arg   = 8'h77;
        rsp_ready = 1'b1;

        // Reset: handshake and strobes forced low while rst_n is low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        check("rst_strobes", {30'd0, ctr_load_enable, ctr_increment}, 0);
        check("rst_outputs", {29'd0, busy, rsp_valid, wrap}, 0);
        check("rst_regs", {16'd0, ctr_load, rsp_data}, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = '0;
        rst_n     = 1'b1;

        // LOAD 0x3C: one load_enable cycle, then ready with new value.
        send(OP_LOAD, 8'h3C);
        @(negedge clk);
        check("load_strobe", {23'd0, ctr_load_enable, ctr_load}, {23'd1, 8'h3C});
        check("load_ready_low", {31'd0, cmd_ready}, 0);
        @(negedge clk);
        check("load_strobe_end", {31'd0, ctr_load_enable}, 0);
        check("load_done", {23'd0, cmd_ready, ctr_value}, {23'd1, 8'h3C});
        @(posedge clk);
        #1;
        do_read(8'h3C);

        // LOAD 0x10, INC 5: five consecutive strobes, ready low five cycles.
        send(OP_LOAD, 8'h10);
        wait_idle();
        send(OP_INC, 8'd5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            inc_mask[i]  = ctr_increment;
            rdy_mask[i]  = cmd_ready;
            both_mask[i] = ctr_increment & ctr_load_enable;
        end
        check("inc5_strobes", {24'd0, inc_mask}, 32'h1F);
        check("inc5_ready", {24'd0, rdy_mask}, 32'hE0);
        check("inc5_exclusive", {24'd0, both_mask}, 0);
        check("inc5_value", {24'd0, ctr_value}, 32'h15);
        @(posedge clk);
        #1;
        do_read(8'h15);

        // LOAD 0xFE, INC 3: wrap pulses once, when the counter shows 0x00.
        send(OP_LOAD, 8'hFE);
        wait_idle();
        send(OP_INC, 8'd3);
        wrap_mask = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wrap_mask[i] = wrap;
            if (i == 2) check("wrap_value", {24'd0, ctr_value}, 0);
        end
        check("wrap_pulse", {24'd0, wrap_mask}, 32'h04);
        @(posedge clk);
        #1;
        do_read(8'h01);

        // Loaded all-ones without an increment must not wrap.
        send(OP_LOAD, 8'hFF);
        wrap_mask = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wrap_mask[i] = wrap;
        end
        check("no_wrap_on_load", {24'd0, wrap_mask}, 0);
        @(posedge clk);
        #1;
        send(OP_LOAD, 8'h01);
        wait_idle();

        // INC 0 then NOP back to back: one cycle each, no strobes.
        cmd_valid = 1'b1;
        cmd_op    = OP_INC;
        cmd_arg   = 8'd0;
        @(negedge clk);
        check("inc0_accept", {29'd0, cmd_ready, ctr_increment, ctr_load_enable}, 32'h4);
        @(posedge clk);
        #1;
        cmd_op = OP_NOP;
        @(negedge clk);
        check("nop_accept", {28'd0, cmd_ready, busy, ctr_increment, ctr_load_enable}, 32'h8);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("inc0_nop_value", {27'd0, busy, ctr_increment, ctr_value}, 32'h01);
        @(posedge clk);
        #1;
        do_read(8'h01);

        // READ stalled by rsp_ready low: response held, no commands taken.
        send(OP_LOAD, 8'hA5);
        wait_idle();
        rsp_ready = 1'b0;
        sb.push_back(8'hA5);
        send(OP_READ, '0);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_arg   = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_hold", {22'd0, rsp_valid, cmd_ready, rsp_data}, {22'd0, 2'b10, 8'hA5});
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_ready", {31'd0, cmd_ready}, 0);
        @(negedge clk);
        check("after_hs", {29'd0, cmd_ready, rsp_valid, ctr_load_enable}, 32'h4);
        @(posedge clk);
        #1;

        // LOAD 0x00, INC 200, reset after 7 increments.
        send(OP_LOAD, 8'h00);
        wait_idle();
        send(OP_INC, 8'd200);
        n = 0;
        for (int i = 0; i < 20 && n < 7; i++) begin
            @(negedge clk);
            if (ctr_increment) n++;
        end
        check("inc200_seen7", n, 7);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_strobe", {30'd0, ctr_increment, cmd_ready}, 0);
        check("abort_value", {24'd0, ctr_value}, 32'h07);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst", {21'd0, busy, ctr_increment, wrap, ctr_value}, 0);
        @(posedge clk);
        #1;
        do_read(8'h00);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_counter_ctrl

// File: doc/counter_ctrl.md
# counter_ctrl

Command sequencer that drives the load/increment interface of the team's 8-bit programmable counter and reads back its value. Accepts LOAD/INC/READ commands over a valid/ready command port, sequences the counter's `load_enable`/`increment` strobes cycle by cycle, and returns read data over a valid/ready response port. It sits between a host-side command source and one counter instance; both blocks share `clk` and `rst_n`.

## Interface
Parameters:
- `WIDTH`, 8: counter data width; widths of `cmd_arg`, `ctr_load`, `ctr_value` and `rsp_data`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when high together with `cmd_valid`.
- `cmd_op`  in  2  opcode: 00 NOP, 01 LOAD, 10 INC, 11 READ.
- `cmd_arg`  in  WIDTH  LOAD value, or INC repeat count; ignored for NOP/READ.
- `rsp_valid`  out  1  read data present.
- `rsp_ready`  in  1  consumer takes read data.
- `rsp_data`  out  WIDTH  sampled counter value.
- `ctr_load`  out  WIDTH  to counter `load`.
- `ctr_load_enable`  out  1  to counter `load_enable`.
- `ctr_increment`  out  1  to counter `increment`.
- `ctr_value`  in  WIDTH  from counter `out`.
- `busy`  out  1  high whenever state != IDLE.
- `wrap`  out  1  one-cycle pulse when an issued increment rolls the counter from all-ones to zero.

## Operation
- States: IDLE, LOAD, INC, RSP.
- `cmd_ready` = (state == IDLE) && `rst_n`. Accept = `cmd_valid` && `cmd_ready`.
- IDLE, accept:
  - NOP → stay in IDLE; no side effect.
  - LOAD → register `cmd_arg` into `ctr_load`; go to LOAD.
  - INC with `cmd_arg` = 0 → stay in IDLE; no strobe.
  - INC with `cmd_arg` = N > 0 → load the repeat register with N; go to INC.
  - READ → capture `ctr_value` into `rsp_data` on the accept edge; go to RSP.
- LOAD: `ctr_load_enable` = 1 for exactly one cycle; then IDLE.
- INC: `ctr_increment` = 1 every cycle in the state. Repeat register decrements each cycle; leave to IDLE after the cycle in which it equals 1.
- RSP: `rsp_valid` = 1, `rsp_data` held stable until `rsp_valid` && `rsp_ready`; then IDLE. No new command is accepted while in RSP.
- `ctr_load_enable` and `ctr_increment` are never high in the same cycle.
- `wrap`: registered. Set in the cycle after a cycle with `ctr_increment` = 1 and `ctr_value` = all-ones. Externally loaded all-ones values followed by no increment never produce `wrap`.
- Width rules: all counter arithmetic is modulo 2^WIDTH. The repeat register is WIDTH bits, so INC maxes out at 2^WIDTH−1 strobes.

## Timing
- Reset (`rst_n` low at an edge): state IDLE; repeat register 0; `ctr_load` 0; `rsp_data` 0; `rsp_valid` 0; `wrap` 0.
- While `rst_n` is low, `cmd_ready`, `ctr_load_enable` and `ctr_increment` are forced to 0 combinationally.
- Reset mid-INC or mid-RSP aborts the operation. The pending response is dropped, and no further strobes are issued after the reset cycle.
- LOAD accepted at edge T: `ctr_load_enable` high in cycle T+1. Counter shows the new value and `cmd_ready` is high from T+2.
- INC N accepted at T: `ctr_increment` high in cycles T+1..T+N. `cmd_ready` is high, and `ctr_value` reflects the old value + N, from T+N+1.
- READ accepted at T: `rsp_valid` high from T+1. `rsp_data` equals the value of `ctr_value` in the accept cycle, which includes every previously completed command.
- Response handshake at edge R: `cmd_ready` is high from R+1.
- Minimum command spacing: NOP or INC 0 is 1 cycle; LOAD is 2 cycles; INC N is N+1 cycles; READ is at least 2 cycles.

## Structure
- Package `counter_ctrl_pkg`: opcode enum (`OP_NOP`, `OP_LOAD`, `OP_INC`, `OP_READ`) and FSM state enum.
- One natural sub-module: `repeat_down_counter`, a WIDTH-bit loadable down-counter with a `last` flag (value == 1) that drives the INC exit. Everything else is inline.

## Test plan
- Reset, then LOAD 0x3C → `ctr_load_enable` high for exactly one cycle with `ctr_load` = 0x3C; a following READ returns `rsp_data` = 0x3C.
- LOAD 0x10, then INC 5 → exactly 5 consecutive `ctr_increment` cycles; READ returns 0x15; `cmd_ready` is low for exactly 5 cycles after the INC accept.
- LOAD 0xFE, then INC 3 → `wrap` pulses once, in the cycle `ctr_value` becomes 0x00; READ returns 0x01.
- INC 0 and NOP back-to-back with `cmd_valid` held high → each accepted in a single cycle; no strobes; counter value unchanged.
- READ with `rsp_ready` held low for 4 cycles → `rsp_valid` and `rsp_data` stay stable and `cmd_ready` stays 0; on `rsp_ready` = 1, the handshake completes and `cmd_ready` returns the next cycle.
- LOAD 0x00, INC 200, assert `rst_n` low after 7 increments → strobes stop immediately; after reset the counter reads 0x00 and `busy` = 0.
